// File: rtl/eforth_pkg.sv
// rtl/eforth_pkg.sv - shared widths, stack op encoding and op classification helpers
package eforth_pkg;

    localparam int DSZ     = 32;
    localparam int S_DEPTH = 64;

    typedef enum logic [2:0] {
        OP_NOP  = 3'd0,
        OP_PUSH = 3'd1,
        OP_DROP = 3'd2,
        OP_DUP  = 3'd3,
        OP_SWAP = 3'd4,
        OP_OVER = 3'd5,
        OP_ROT  = 3'd6,
        OP_LOAD = 3'd7
    } stk_op_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ROT2 = 1'b1
    } dstk_state_t;

    // Minimum number of items an op needs on the stack before it may run.
    function automatic logic [1:0] min_depth(stk_op_t o);
        case (o)
            OP_DROP, OP_DUP, OP_LOAD: return 2'd1;
            OP_SWAP, OP_OVER:         return 2'd2;
            OP_ROT:                   return 2'd3;
            default:                  return 2'd0;
        endcase
    endfunction

    // Ops that add one item to the stack.
    function automatic logic grows(stk_op_t o);
        return (o == OP_PUSH) || (o == OP_DUP) || (o == OP_OVER);
    endfunction

endpackage

// File: rtl/dstack_ctrl.sv
// rtl/dstack_ctrl.sv - Forth data-stack controller caching TOS/NOS in front of stack3
//
// Ports:
//   clk, rst            clock; asynchronous active-low reset
//   op_valid/op_ready   op handshake; op is a stk_op_t code, din the PUSH/LOAD operand
//   tos, nos, depth     registered top two cells and total item count (cached + spilled)
//   err_ovf, err_unf    one-cycle pulses for an op rejected on full / too-few items
//   s_push, s_pop, s_vi stack3 control and write data (combinational)
//   s_vo                stack3 top of memory, combinational from the memory
module dstack_ctrl #(
    parameter int DSZ   = eforth_pkg::DSZ,
    parameter int DEPTH = eforth_pkg::S_DEPTH,
    parameter int CSZ   = $clog2(DEPTH + 3)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           op_valid,
    output logic           op_ready,
    input  logic [2:0]     op,
    input  logic [DSZ-1:0] din,
    output logic [DSZ-1:0] tos,
    output logic [DSZ-1:0] nos,
    output logic [CSZ-1:0] depth,
    output logic           err_ovf,
    output logic           err_unf,
    output logic           s_push,
    output logic           s_pop,
    output logic [DSZ-1:0] s_vi,
    input  logic [DSZ-1:0] s_vo
);
    import eforth_pkg::*;

    // Two cached cells plus a full memory.
    localparam logic [CSZ-1:0] MAX_DEPTH = CSZ'(DEPTH + 2);
    localparam logic [CSZ-1:0] ONE       = CSZ'(1);
    localparam logic [CSZ-1:0] TWO       = CSZ'(2);

    dstk_state_t    state, state_nx;
    stk_op_t        op_e;
    logic           accept;
    logic           too_few, too_full;
    logic [DSZ-1:0] push_val;
    logic [DSZ-1:0] tos_nx, nos_nx;
    logic [DSZ-1:0] tmp2, tmp2_nx;   // holds old nos (b) across the ROT write-back cycle
    logic [CSZ-1:0] depth_nx;
    logic           ovf_nx, unf_nx;

    assign op_e     = stk_op_t'(op);
    assign op_ready = (state == ST_IDLE);
    assign accept   = op_valid & op_ready;

    assign too_few  = depth < {{(CSZ-2){1'b0}}, min_depth(op_e)};
    assign too_full = grows(op_e) && (depth == MAX_DEPTH);

    always_comb begin
        case (op_e)
            OP_DUP:  push_val = tos;
            OP_OVER: push_val = nos;
            default: push_val = din;
        endcase
    end

    always_comb begin
        state_nx = state;
        tos_nx   = tos;
        nos_nx   = nos;
        tmp2_nx  = tmp2;
        depth_nx = depth;
        ovf_nx   = 1'b0;
        unf_nx   = 1'b0;
        s_push   = 1'b0;
        s_pop    = 1'b0;
        s_vi     = nos;

        case (state)
            ST_IDLE: begin
                if (accept) begin
                    if (too_few) begin
                        unf_nx = 1'b1;
                    end else if (too_full) begin
                        ovf_nx = 1'b1;
                    end else begin
                        case (op_e)
                            OP_PUSH, OP_DUP, OP_OVER: begin
                                // Old nos only needs a home in memory if it was a live cell.
                                s_push   = (depth >= TWO);
                                nos_nx   = tos;
                                tos_nx   = push_val;
                                depth_nx = depth + ONE;
                            end
                            OP_DROP: begin
                                tos_nx   = nos;
                                depth_nx = depth - ONE;
                                // Refill nos only when memory actually holds something.
                                if (depth > TWO) begin
                                    s_pop  = 1'b1;
                                    nos_nx = s_vo;
                                end
                            end
                            OP_SWAP: begin
                                tos_nx = nos;
                                nos_nx = tos;
                            end
                            OP_ROT: begin
                                // (a b c -- b c a): pull a out now, write b back next cycle.
                                s_pop    = 1'b1;
                                tos_nx   = s_vo;
                                nos_nx   = tos;
                                tmp2_nx  = nos;
                                state_nx = ST_ROT2;
                            end
                            OP_LOAD: begin
                                tos_nx = din;
                            end
                            default: begin
                            end
                        endcase
                    end
                end
            end
            ST_ROT2: begin
                s_push   = 1'b1;
                s_vi     = tmp2;
                state_nx = ST_IDLE;
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= ST_IDLE;
            tos     <= '0;
            nos     <= '0;
            tmp2    <= '0;
            depth   <= '0;
            err_ovf <= 1'b0;
            err_unf <= 1'b0;
        end else begin
            state   <= state_nx;
            tos     <= tos_nx;
            nos     <= nos_nx;
            tmp2    <= tmp2_nx;
            depth   <= depth_nx;
            err_ovf <= ovf_nx;
            err_unf <= unf_nx;
        end
    end

endmodule
